camera_capture_sequencer: RTL and testbench
===========================================

# camera_capture_sequencer

Single-clock sequencer that arms, runs and closes one still-image capture into the camera image buffer, then serves sequential host reads out of that buffer. It sits between the host command decoder (capture/read pulses, byte-count queries) and the buffer port. It consumes cropped, packed 8-bit pixels and frame/line valid strobes already synchronised into its clock domain. It owns the buffer address and the write enable, so the buffer never sees a write and a read in the same cycle.

## Interface
Parameters:
- CAPTURE_SIZE, 40000: maximum bytes stored per capture (200 × 200 RGB332).
- ADDRESS_WIDTH, 16: buffer address and byte-counter width; CAPTURE_SIZE ≤ 2^ADDRESS_WIDTH − 1.
- TIMEOUT_CYCLES, 7200000: cycles ARMED waits for a frame start before aborting (100 ms at 72 MHz).

Ports:
- clock_in  input  1  system clock; one clock domain, all logic on rising edge.
- reset_in  input  1  synchronous, active-high reset.
- capture_request_in  input  1  single-cycle capture command.
- frame_valid_in  input  1  cropped frame valid.
- line_valid_in  input  1  cropped line valid.
- pixel_data_in  input  8  packed pixel, qualified by frame_valid_in && line_valid_in.
- read_request_in  input  1  single-cycle request for the next stored byte.
- buffer_read_data_in  input  8  buffer read data, valid 1 cycle after the address.
- buffer_address_out  output  ADDRESS_WIDTH  shared write/read address.
- buffer_write_data_out  output  8  write data.
- buffer_write_enable_out  output  1  write strobe.
- read_data_out  output  8  byte returned to host.
- read_valid_out  output  1  one-cycle pulse qualifying read_data_out.
- bytes_remaining_out  output  ADDRESS_WIDTH  unread stored bytes.
- busy_out  output  1  high in ARMED or CAPTURING.
- done_out  output  1  high in DONE.
- timeout_out  output  1  sticky; last arm expired without a frame.
- overflow_out  output  1  sticky; last frame had more than CAPTURE_SIZE pixels.

## Operation
- States: IDLE, ARMED, CAPTURING, DONE. Reset → IDLE. Reset drives every output and counter to 0.
- IDLE or DONE, capture_request_in=1 → ARMED next cycle. This clears write_count, read_count, timeout_out, overflow_out and the timeout counter.
- capture_request_in in ARMED or CAPTURING is ignored.
- Frame start is frame_valid_in=1 with last-cycle frame_valid_in=0 (registered history, 0 after reset). If frame_valid_in is already high at arm time, the sequencer waits for the next rising edge.
- ARMED, frame start → CAPTURING. The pixel in the edge cycle is accepted if line_valid_in=1.
- ARMED, timeout counter reaches TIMEOUT_CYCLES → IDLE with timeout_out=1. Frame start in that same cycle wins.
- A pixel is accepted when frame_valid_in && line_valid_in. If write_count < CAPTURE_SIZE, it is written at address write_count and write_count increments. Otherwise it is dropped and overflow_out is set to 1.
- CAPTURING, frame_valid_in=0 → DONE. The stored length is write_count, which may be less than CAPTURE_SIZE.
- DONE, read_request_in=1 with no read in flight: read_count < write_count issues a buffer read at address read_count, then read_count increments. If read_count = write_count, the read returns 0x00 and the pointer holds.
- read_request_in while a read is in flight, or outside DONE, is dropped. It produces no read_valid_out.
- bytes_remaining_out = write_count − read_count in DONE, 0 in every other state.
- buffer_address_out shows the write address on write cycles and the read address on read-issue cycles. Otherwise it holds its last value.
- Reset mid-capture or mid-read aborts immediately. No write or read_valid_out occurs after the reset cycle.

## Timing
- Accepted pixel in cycle N → buffer_write_enable_out=1 with address and data registered in N+1. One write per accepted pixel; no bubbles inserted.
- Read request in cycle N → address driven in N+1 → buffer data in N+2 → read_data_out registered and read_valid_out=1 in N+3. Back-to-back reads are possible every 3 cycles.
- State transitions take effect the cycle after the triggering condition. busy_out and done_out are decoded from registered state.
- The timeout counter increments each ARMED cycle, starting at 0 on the ARMED entry cycle.

## Test plan
- CAPTURE_SIZE=16: capture request, 4 lines × 4 pixels of 0x00–0x0F, frame ends → 16 writes at addresses 0–15 with matching data, done_out=1, bytes_remaining_out=16, overflow_out=0.
- Same setup: 5 lines × 4 pixels → writes stop at address 15, overflow_out=1, bytes_remaining_out=16.
- TIMEOUT_CYCLES=100: capture request with frame_valid_in held low → IDLE after 100 ARMED cycles, timeout_out=1, busy_out=0, no writes.
- Arm while frame_valid_in is already high mid-frame → no writes until frame_valid_in falls and rises again; the next frame is captured fully.
- After a 16-byte capture, 17 reads spaced 3 cycles apart (buffer model returns address as data) → read_data_out 0x00–0x0F, then 0x00 with bytes_remaining_out held at 0. A request issued 1 cycle after another gets no response.
- Assert reset_in while CAPTURING at write_count=7 → next cycle IDLE, all outputs 0. A new capture request starts writing again at address 0.

Source files
------------

// File: rtl/camera_capture_sequencer.sv
// Arms, runs and closes one still capture into the image buffer, then serves sequential host reads.
// Latency: accepted pixel -> buffer write 1 cycle; read request -> read_valid_out 3 cycles.
// No backpressure: pixels beyond capture size are dropped, and reads in flight or outside DONE are ignored.
module camera_capture_sequencer #(
    parameter int CAPTURE_SIZE   = 40000,
    parameter int ADDRESS_WIDTH  = 16,
    parameter int TIMEOUT_CYCLES = 7200000
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic                     capture_request_in,
    input  logic                     frame_valid_in,
    input  logic                     line_valid_in,
    input  logic [7:0]               pixel_data_in,
    input  logic                     read_request_in,
    input  logic [7:0]               buffer_read_data_in,
    output logic [ADDRESS_WIDTH-1:0] buffer_address_out,
    output logic [7:0]               buffer_write_data_out,
    output logic                     buffer_write_enable_out,
    output logic [7:0]               read_data_out,
    output logic                     read_valid_out,
    output logic [ADDRESS_WIDTH-1:0] bytes_remaining_out,
    output logic                     busy_out,
    output logic                     done_out,
    output logic                     timeout_out,
    output logic                     overflow_out
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]            TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDRESS_WIDTH-1:0] CAP_LIMIT = ADDRESS_WIDTH'(CAPTURE_SIZE);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURING,
        ST_DONE
    } state_t;

    state_t                   state_q, state_d;
    logic                     fv_prev_q, fv_prev_d;
    logic [TW-1:0]            tmo_cnt_q, tmo_cnt_d;
    logic [ADDRESS_WIDTH-1:0] write_count_q, write_count_d;
    logic [ADDRESS_WIDTH-1:0] read_count_q, read_count_d;
    logic                     timeout_q, timeout_d;
    logic                     overflow_q, overflow_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]               wdata_q, wdata_d;
    logic                     wen_q, wen_d;
    logic                     rd_issue_q, rd_issue_d;
    logic                     rd_wait_q, rd_wait_d;
    logic                     rd_empty1_q, rd_empty1_d;
    logic                     rd_empty2_q, rd_empty2_d;
    logic [7:0]               read_data_q, read_data_d;
    logic                     read_valid_q, read_valid_d;

    logic frame_start;
    logic pixel_ok;
    logic arm;
    logic accept;

    assign frame_start = frame_valid_in && !fv_prev_q;
    assign pixel_ok    = frame_valid_in && line_valid_in;

    always_comb begin
        state_d       = state_q;
        fv_prev_d     = frame_valid_in;
        tmo_cnt_d     = tmo_cnt_q;
        write_count_d = write_count_q;
        read_count_d  = read_count_q;
        timeout_d     = timeout_q;
        overflow_d    = overflow_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        wen_d         = 1'b0;
        rd_issue_d    = 1'b0;
        rd_wait_d     = rd_issue_q;
        rd_empty1_d   = 1'b0;
        rd_empty2_d   = rd_empty1_q;
        read_valid_d  = rd_wait_q;
        read_data_d   = read_data_q;
        arm           = 1'b0;
        accept        = 1'b0;

        // Empty reads still run the full pipeline so the host sees uniform latency.
        if (rd_wait_q) begin
            read_data_d = rd_empty2_q ? 8'h00 : buffer_read_data_in;
        end

        case (state_q)
            ST_IDLE: begin
                arm = capture_request_in;
            end
            ST_ARMED: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (frame_start) begin
                    state_d = ST_CAPTURING;
                    accept  = pixel_ok;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_CAPTURING: begin
                if (!frame_valid_in) begin
                    state_d = ST_DONE;
                end else begin
                    accept = pixel_ok;
                end
            end
            ST_DONE: begin
                if (capture_request_in) begin
                    arm = 1'b1;
                end else if (read_request_in && !rd_issue_q && !rd_wait_q) begin
                    rd_issue_d = 1'b1;
                    if (read_count_q < write_count_q) begin
                        addr_d       = read_count_q;
                        read_count_d = read_count_q + 1'b1;
                    end else begin
                        rd_empty1_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (arm) begin
            state_d       = ST_ARMED;
            tmo_cnt_d     = '0;
            write_count_d = '0;
            read_count_d  = '0;
            timeout_d     = 1'b0;
            overflow_d    = 1'b0;
        end

        if (accept) begin
            if (write_count_q < CAP_LIMIT) begin
                wen_d         = 1'b1;
                addr_d        = write_count_q;
                wdata_d       = pixel_data_in;
                write_count_d = write_count_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q       <= ST_IDLE;
            fv_prev_q     <= 1'b0;
            tmo_cnt_q     <= '0;
            write_count_q <= '0;
            read_count_q  <= '0;
            timeout_q     <= 1'b0;
            overflow_q    <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wen_q         <= 1'b0;
            rd_issue_q    <= 1'b0;
            rd_wait_q     <= 1'b0;
            rd_empty1_q   <= 1'b0;
            rd_empty2_q   <= 1'b0;
            read_data_q   <= '0;
            read_valid_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            fv_prev_q     <= fv_prev_d;
            tmo_cnt_q     <= tmo_cnt_d;
            write_count_q <= write_count_d;
            read_count_q  <= read_count_d;
            timeout_q     <= timeout_d;
            overflow_q    <= overflow_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            wen_q         <= wen_d;
            rd_issue_q    <= rd_issue_d;
            rd_wait_q     <= rd_wait_d;
            rd_empty1_q   <= rd_empty1_d;
            rd_empty2_q   <= rd_empty2_d;
            read_data_q   <= read_data_d;
            read_valid_q  <= read_valid_d;
        end
    end

    assign buffer_address_out      = addr_q;
    assign buffer_write_data_out   = wdata_q;
    assign buffer_write_enable_out = wen_q;
    assign read_data_out           = read_data_q;
    assign read_valid_out          = read_valid_q;
    assign bytes_remaining_out     = (state_q == ST_DONE) ? (write_count_q - read_count_q) : '0;
    assign busy_out                = (state_q == ST_ARMED) || (state_q == ST_CAPTURING);
    assign done_out                = (state_q == ST_DONE);
    assign timeout_out             = timeout_q;
    assign overflow_out            = overflow_q;

endmodule

// File: tb/tb_camera_capture_sequencer.sv
// Directed bench for camera_capture_sequencer with a 16-byte buffer and a 100-cycle arm timeout.
module tb_camera_capture_sequencer;
    logic        clk = 1'b0;
    logic        reset_in = 1'b1;
    logic        capture_request_in = 1'b0;
    logic        frame_valid_in = 1'b0;
    logic        line_valid_in = 1'b0;
    logic [7:0]  pixel_data_in = 8'h00;
    logic        read_request_in = 1'b0;
    logic [7:0]  buffer_read_data_in = 8'h00;
    logic [15:0] buffer_address_out;
    logic [7:0]  buffer_write_data_out;
    logic        buffer_write_enable_out;
    logic [7:0]  read_data_out;
    logic        read_valid_out;
    logic [15:0] bytes_remaining_out;
    logic        busy_out;
    logic        done_out;
    logic        timeout_out;
    logic        overflow_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] wr_addr_log[$];
    logic [7:0]  wr_data_log[$];
    int          rv_cnt = 0;

    always #5 clk = ~clk;

    camera_capture_sequencer #(
        .CAPTURE_SIZE(16),
        .ADDRESS_WIDTH(16),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clock_in(clk),
        .reset_in(reset_in),
        .capture_request_in(capture_request_in),
        .frame_valid_in(frame_valid_in),
        .line_valid_in(line_valid_in),
        .pixel_data_in(pixel_data_in),
        .read_request_in(read_request_in),
        .buffer_read_data_in(buffer_read_data_in),
        .buffer_address_out(buffer_address_out),
        .buffer_write_data_out(buffer_write_data_out),
        .buffer_write_enable_out(buffer_write_enable_out),
        .read_data_out(read_data_out),
        .read_valid_out(read_valid_out),
        .bytes_remaining_out(bytes_remaining_out),
        .busy_out(busy_out),
        .done_out(done_out),
        .timeout_out(timeout_out),
        .overflow_out(overflow_out)
    );

    // Buffer model: returns the low address byte one cycle after the address.
    always @(posedge clk) buffer_read_data_in <= buffer_address_out[7:0];

    always @(negedge clk) begin
        if (buffer_write_enable_out) begin
            wr_addr_log.push_back(buffer_address_out);
            wr_data_log.push_back(buffer_write_data_out);
        end
        if (read_valid_out) rv_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic arm();
        capture_request_in = 1'b1;
        step();
        capture_request_in = 1'b0;
    endtask

    task automatic drive_frame(input int lines, input int start);
        int v;
        v = start;
        for (int l = 0; l < lines; l++) begin
            for (int p = 0; p < 4; p++) begin
                frame_valid_in = 1'b1;
                line_valid_in  = 1'b1;
                pixel_data_in  = 8'(v);
                v++;
                step();
            end
            line_valid_in = 1'b0;
            step();
        end
        frame_valid_in = 1'b0;
        line_valid_in  = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_in = 1'b1;
        step();
        step();
        n_cmp++;
        if ({buffer_address_out, buffer_write_data_out, buffer_write_enable_out, read_data_out,
             read_valid_out, bytes_remaining_out, busy_out, done_out, timeout_out, overflow_out} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: some output nonzero (addr=%0h busy=%0b done=%0b)",
                     buffer_address_out, busy_out, done_out);
        end
        reset_in = 1'b0;
        step();
        n_cmp++;
        if (busy_out !== 1'b0) begin n_bad++; $display("FAIL reset_idle_busy: got %0b expected 0", busy_out); end
    endtask

    task automatic test_capture_full();
        int b;
        b = wr_addr_log.size();
        arm();
        n_cmp++;
        if (busy_out !== 1'b1) begin n_bad++; $display("FAIL full_armed_busy: got %0b expected 1", busy_out); end
        drive_frame(4, 0);
        n_cmp++;
        if (wr_addr_log.size() - b != 16) begin
            n_bad++; $display("FAIL full_write_count: got %0d expected 16", wr_addr_log.size() - b);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (wr_addr_log[b+i] !== 16'(i) || wr_data_log[b+i] !== 8'(i)) begin
                    n_bad++;
                    $display("FAIL full_write_%0d: got addr %0h data %0h expected %0h/%0h",
                             i, wr_addr_log[b+i], wr_data_log[b+i], i, i);
                end
            end
        end
        n_cmp++;
        if (done_out !== 1'b1) begin n_bad++; $display("FAIL full_done: got %0b expected 1", done_out); end
        n_cmp++;
        if (bytes_remaining_out !== 16'd16) begin
            n_bad++; $display("FAIL full_remaining: got %0d expected 16", bytes_remaining_out);
        end
        n_cmp++;
        if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL full_overflow: got %0b expected 0", overflow_out); end
    endtask

    task automatic test_overflow();
        int b;
        b = wr_addr_log.size();
        arm();
        drive_frame(5, 0);
        n_cmp++;
        if (wr_addr_log.size() - b != 16) begin
            n_bad++; $display("FAIL ovf_write_count: got %0d expected 16", wr_addr_log.size() - b);
        end else begin
            n_cmp++;
            if (wr_addr_log[b+15] !== 16'd15 || wr_data_log[b+15] !== 8'h0F) begin
                n_bad++;
                $display("FAIL ovf_last_write: got addr %0h data %0h expected f/f", wr_addr_log[b+15], wr_data_log[b+15]);
            end
        end
        n_cmp++;
        if (overflow_out !== 1'b1) begin n_bad++; $display("FAIL ovf_flag: got %0b expected 1", overflow_out); end
        n_cmp++;
        if (bytes_remaining_out !== 16'd16) begin
            n_bad++; $display("FAIL ovf_remaining: got %0d expected 16", bytes_remaining_out);
        end
    endtask

    task automatic test_timeout();
        int b;
        b = wr_addr_log.size();
        arm();
        n_cmp++;
        if (overflow_out !== 1'b0) begin n_bad++; $display("FAIL tmo_arm_clears_ovf: got %0b expected 0", overflow_out); end
        for (int i = 0; i < 99; i++) step();
        n_cmp++;
        if (busy_out !== 1'b1 || timeout_out !== 1'b0) begin
            n_bad++; $display("FAIL tmo_before: got busy %0b timeout %0b expected 1/0", busy_out, timeout_out);
        end
        step();
        n_cmp++;
        if (busy_out !== 1'b0 || timeout_out !== 1'b1 || done_out !== 1'b0) begin
            n_bad++;
            $display("FAIL tmo_expired: got busy %0b timeout %0b done %0b expected 0/1/0", busy_out, timeout_out, done_out);
        end
        n_cmp++;
        if (wr_addr_log.size() != b) begin n_bad++; $display("FAIL tmo_no_writes: got %0d expected 0", wr_addr_log.size() - b); end
    endtask

    task automatic test_arm_mid_frame();
        int b;
        b = wr_addr_log.size();
        frame_valid_in = 1'b1;
        line_valid_in  = 1'b0;
        step();
        step();
        capture_request_in = 1'b1;
        line_valid_in      = 1'b1;
        pixel_data_in      = 8'h33;
        step();
        capture_request_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            pixel_data_in = 8'(8'h34 + i);
            step();
        end
        n_cmp++;
        if (wr_addr_log.size() != b || busy_out !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_no_capture: got writes %0d busy %0b expected 0/1", wr_addr_log.size() - b, busy_out);
        end
        frame_valid_in = 1'b0;
        line_valid_in  = 1'b0;
        step();
        step();
        drive_frame(4, 8'h40);
        n_cmp++;
        if (wr_addr_log.size() - b != 16) begin
            n_bad++; $display("FAIL mid_write_count: got %0d expected 16", wr_addr_log.size() - b);
        end else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (wr_addr_log[b+i] !== 16'(i) || wr_data_log[b+i] !== 8'(8'h40 + i)) begin
                    n_bad++;
                    $display("FAIL mid_write_%0d: got addr %0h data %0h expected %0h/%0h",
                             i, wr_addr_log[b+i], wr_data_log[b+i], i, 8'h40 + i);
                end
            end
        end
        n_cmp++;
        if (done_out !== 1'b1) begin n_bad++; $display("FAIL mid_done: got %0b expected 1", done_out); end
    endtask

    task automatic test_reads();
        int base;
        logic [7:0]  exp_data;
        logic [15:0] exp_rem;
        for (int i = 0; i < 17; i++) begin
            read_request_in = 1'b1;
            step();
            read_request_in = 1'b0;
            step();
            if (i == 0) begin
                n_cmp++;
                if (read_valid_out !== 1'b0) begin n_bad++; $display("FAIL rd_early_valid: got %0b expected 0", read_valid_out); end
            end
            step();
            exp_data = (i < 16) ? 8'(i) : 8'h00;
            exp_rem  = (i < 16) ? 16'(15 - i) : 16'd0;
            n_cmp++;
            if (read_valid_out !== 1'b1 || read_data_out !== exp_data) begin
                n_bad++;
                $display("FAIL rd_%0d: got valid %0b data %0h expected 1/%0h", i, read_valid_out, read_data_out, exp_data);
            end
            n_cmp++;
            if (bytes_remaining_out !== exp_rem) begin
                n_bad++; $display("FAIL rd_rem_%0d: got %0d expected %0d", i, bytes_remaining_out, exp_rem);
            end
        end
        step();
        base = rv_cnt;
        read_request_in = 1'b1;
        step();
        step();
        read_request_in = 1'b0;
        for (int i = 0; i < 6; i++) step();
        n_cmp++;
        if (rv_cnt - base != 1) begin n_bad++; $display("FAIL rd_dropped: got %0d responses expected 1", rv_cnt - base); end
        n_cmp++;
        if (bytes_remaining_out !== 16'd0) begin n_bad++; $display("FAIL rd_hold: got %0d expected 0", bytes_remaining_out); end
    endtask

    task automatic test_reset_mid_capture();
        int b;
        int b2;
        b = wr_addr_log.size();
        arm();
        for (int p = 0; p < 7; p++) begin
            frame_valid_in = 1'b1;
            line_valid_in  = 1'b1;
            pixel_data_in  = 8'(8'h80 + p);
            step();
            if (p == 0) begin
                n_cmp++;
                if (buffer_write_enable_out !== 1'b1 || buffer_address_out !== 16'd0 || buffer_write_data_out !== 8'h80) begin
                    n_bad++;
                    $display("FAIL rst_first_write: got en %0b addr %0h data %0h expected 1/0/80",
                             buffer_write_enable_out, buffer_address_out, buffer_write_data_out);
                end
            end
        end
        reset_in      = 1'b1;
        pixel_data_in = 8'h87;
        step();
        reset_in       = 1'b0;
        frame_valid_in = 1'b0;
        line_valid_in  = 1'b0;
        n_cmp++;
        if ({buffer_address_out, buffer_write_data_out, buffer_write_enable_out, read_data_out,
             read_valid_out, bytes_remaining_out, busy_out, done_out, timeout_out, overflow_out} !== '0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got addr %0h data %0h en %0b busy %0b expected all 0",
                     buffer_address_out, buffer_write_data_out, buffer_write_enable_out, busy_out);
        end
        step();
        n_cmp++;
        if (wr_addr_log.size() - b != 7) begin n_bad++; $display("FAIL rst_mid_writes: got %0d expected 7", wr_addr_log.size() - b); end
        b2 = wr_addr_log.size();
        arm();
        drive_frame(1, 8'h90);
        n_cmp++;
        if (wr_addr_log.size() - b2 != 4) begin
            n_bad++; $display("FAIL rst_recapture_count: got %0d expected 4", wr_addr_log.size() - b2);
        end else begin
            n_cmp++;
            if (wr_addr_log[b2] !== 16'd0 || wr_data_log[b2] !== 8'h90) begin
                n_bad++; $display("FAIL rst_recapture_first: got addr %0h data %0h expected 0/90", wr_addr_log[b2], wr_data_log[b2]);
            end
        end
        n_cmp++;
        if (done_out !== 1'b1 || bytes_remaining_out !== 16'd4) begin
            n_bad++; $display("FAIL rst_recapture_done: got done %0b rem %0d expected 1/4", done_out, bytes_remaining_out);
        end
    endtask

    initial begin
        test_reset();
        test_capture_full();
        test_overflow();
        test_timeout();
        test_arm_mid_frame();
        test_reads();
        test_reset_mid_capture();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
